// File: rtl/instruction_encoder_loader.sv
// Packs decoded DLX instruction fields into 32-bit words, buffers them in a small FIFO and
// streams them to instruction memory at auto-incrementing byte addresses.
module instruction_encoder_loader #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned OPCODE_WIDTH      = 6,
  parameter int unsigned FUNCTION_WIDTH    = 6,
  parameter int unsigned REG_ADDR_WIDTH    = 5,
  parameter int unsigned IMEDIATE_WIDTH    = 16,
  parameter int unsigned PC_OFFSET_WIDTH   = 26,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_in,
  input  logic [ADDR_WIDTH-1:0]        start_addr_in,
  input  logic                         end_in,
  input  logic                         enc_valid_in,
  output logic                         enc_ready_out,
  input  logic [1:0]                   fmt_in,
  input  logic [OPCODE_WIDTH-1:0]      opcode_in,
  input  logic [REG_ADDR_WIDTH-1:0]    rs1_in,
  input  logic [REG_ADDR_WIDTH-1:0]    rs2_in,
  input  logic [REG_ADDR_WIDTH-1:0]    rd_in,
  input  logic [FUNCTION_WIDTH-1:0]    function_in,
  input  logic [IMEDIATE_WIDTH-1:0]    immediate_in,
  input  logic [PC_OFFSET_WIDTH-1:0]   pc_offset_in,
  output logic                         imem_wr_en_out,
  output logic [ADDR_WIDTH-1:0]        imem_addr_out,
  output logic [INSTRUCTION_WIDTH-1:0] imem_data_out,
  input  logic                         imem_wr_ack_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         err_out,
  output logic [15:0]                  word_count_out
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned OpMsb  = INSTRUCTION_WIDTH - 1;
  localparam int unsigned Rs1Msb = OpMsb - OPCODE_WIDTH;
  localparam int unsigned Rs2Msb = Rs1Msb - REG_ADDR_WIDTH;
  localparam int unsigned RdRMsb = Rs2Msb - REG_ADDR_WIDTH;

  localparam logic [PtrW:0] FillFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [1:0]    FmtR     = 2'd0;
  localparam logic [1:0]    FmtI     = 2'd1;
  localparam logic [1:0]    FmtJ     = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [15:0]                 count_q, count_d;
  logic                        err_q, err_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]               fill_q, fill_d;
  logic [INSTRUCTION_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [INSTRUCTION_WIDTH-1:0] enc_word;
  logic                         enc_illegal;
  logic                         fifo_empty, fifo_full, active, push, pop;

  // Field packing; an illegal format becomes an all-zero NOP word.
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (fmt_in)
      FmtR: begin
        enc_word[OpMsb -: OPCODE_WIDTH]      = opcode_in;
        enc_word[Rs1Msb -: REG_ADDR_WIDTH]   = rs1_in;
        enc_word[Rs2Msb -: REG_ADDR_WIDTH]   = rs2_in;
        enc_word[RdRMsb -: REG_ADDR_WIDTH]   = rd_in;
        enc_word[FUNCTION_WIDTH-1:0]         = function_in;
      end
      FmtI: begin
        enc_word[OpMsb -: OPCODE_WIDTH]      = opcode_in;
        enc_word[Rs1Msb -: REG_ADDR_WIDTH]   = rs1_in;
        enc_word[Rs2Msb -: REG_ADDR_WIDTH]   = rd_in;
        enc_word[IMEDIATE_WIDTH-1:0]         = immediate_in;
      end
      FmtJ: begin
        enc_word[OpMsb -: OPCODE_WIDTH]      = opcode_in;
        enc_word[PC_OFFSET_WIDTH-1:0]        = pc_offset_in;
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  assign active     = (state_q == StRun) || (state_q == StDrain);
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == FillFull);

  assign enc_ready_out  = (state_q == StRun) && !fifo_full;
  assign push           = enc_valid_in && enc_ready_out;
  assign imem_wr_en_out = active && !fifo_empty;
  assign pop            = imem_wr_en_out && imem_wr_ack_in;

  // Data is masked while idle so every output reads zero out of reset.
  assign imem_data_out  = imem_wr_en_out ? mem[rd_ptr_q] : '0;
  assign imem_addr_out  = addr_q;
  assign busy_out       = (state_q != StIdle);
  assign done_out       = (state_q == StDone);
  assign err_out        = err_q;
  assign word_count_out = count_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (enc_illegal) begin
        err_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      addr_d   = addr_q + ADDR_WIDTH'(4);
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end

    fill_d = fill_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StRun;
          addr_d  = start_addr_in & ~ADDR_WIDTH'(3);
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (end_in) begin
          state_d = StDrain;
        end
      end
      // An empty FIFO means the last head has been acknowledged.
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Randomized bench for instruction_encoder_loader against a queue-based behavioural model;
// a second instance with an 8-bit address bus shares the stimulus.
module tb_instruction_encoder_loader;

  localparam int Depth = 4;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [31:0] start_addr;
  logic        end_in;
  logic        enc_valid;
  logic        ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic [25:0] off;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ack;
  logic        busy, done, err;
  logic [15:0] count;

  logic        d8_ready, d8_wr_en, d8_busy, d8_done, d8_err;
  logic [7:0]  d8_addr;
  logic [31:0] d8_data;
  logic [15:0] d8_count;

  int n_total;
  int n_bad;
  int ack_pct;
  int ack_low;

  typedef enum int {MIdle, MRun, MDrain, MDone} mode_e;
  mode_e       m_mode;
  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  int unsigned m_cnt;
  bit          m_err;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  log8_addr[$];

  instruction_encoder_loader u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .start_addr_in (start_addr),
    .end_in        (end_in),
    .enc_valid_in  (enc_valid),
    .enc_ready_out (ready),
    .fmt_in        (fmt),
    .opcode_in     (opcode),
    .rs1_in        (rs1),
    .rs2_in        (rs2),
    .rd_in         (rd),
    .function_in   (fn),
    .immediate_in  (imm),
    .pc_offset_in  (off),
    .imem_wr_en_out(wr_en),
    .imem_addr_out (addr),
    .imem_data_out (data),
    .imem_wr_ack_in(ack),
    .busy_out      (busy),
    .done_out      (done),
    .err_out       (err),
    .word_count_out(count)
  );

  instruction_encoder_loader #(.ADDR_WIDTH(8)) u_dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .start_addr_in (start_addr[7:0]),
    .end_in        (end_in),
    .enc_valid_in  (enc_valid),
    .enc_ready_out (d8_ready),
    .fmt_in        (fmt),
    .opcode_in     (opcode),
    .rs1_in        (rs1),
    .rs2_in        (rs2),
    .rd_in         (rd),
    .function_in   (fn),
    .immediate_in  (imm),
    .pc_offset_in  (off),
    .imem_wr_en_out(d8_wr_en),
    .imem_addr_out (d8_addr),
    .imem_data_out (d8_data),
    .imem_wr_ack_in(ack),
    .busy_out      (d8_busy),
    .done_out      (d8_done),
    .err_out       (d8_err),
    .word_count_out(d8_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input int unsigned f, input int unsigned op,
                                         input int unsigned r1, input int unsigned r2,
                                         input int unsigned rdst, input int unsigned fc,
                                         input int unsigned im, input int unsigned po);
    case (f)
      0:       return (op << 26) | (r1 << 21) | (r2 << 16) | (rdst << 11) | fc;
      1:       return (op << 26) | (r1 << 21) | (rdst << 16) | im;
      2:       return (op << 26) | po;
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: evaluated mid-cycle, then advanced to what the next edge should do.
  always @(negedge clk) begin
    int sz;
    bit exp_wr;
    if (!rst_n) begin
      m_mode = MIdle;
      m_q.delete();
      m_addr = '0;
      m_cnt  = 0;
      m_err  = 1'b0;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end else begin
      sz     = m_q.size();
      exp_wr = (m_mode == MRun || m_mode == MDrain) && sz > 0;
      check("ready", 32'(ready), 32'(m_mode == MRun && sz < Depth));
      check("wr_en", 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
        check("addr", addr, m_addr);
        check("data", data, m_q[0]);
        check("d8_addr", 32'(d8_addr), 32'(m_addr[7:0]));
        check("d8_data", d8_data, m_q[0]);
      end
      check("d8_wr_en", 32'(d8_wr_en), 32'(exp_wr));
      check("busy", 32'(busy), 32'(m_mode != MIdle));
      check("done", 32'(done), 32'(m_mode == MDone));
      check("err", 32'(err), 32'(m_err));
      check("count", 32'(count), m_cnt);

      if (wr_en && ack) begin
        log_addr.push_back(addr);
        log_data.push_back(data);
      end
      if (d8_wr_en && ack) log8_addr.push_back(d8_addr);

      case (m_mode)
        MIdle: begin
          if (start_in) begin
            m_mode = MRun;
            m_addr = start_addr & 32'hFFFF_FFFC;
            m_cnt  = 0;
            m_err  = 1'b0;
          end
        end
        MRun, MDrain: begin
          if (sz > 0 && ack) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
            if (m_cnt < 65535) m_cnt++;
          end
          if (m_mode == MRun && enc_valid && sz < Depth) begin
            m_q.push_back(encode(32'(fmt), 32'(opcode), 32'(rs1), 32'(rs2), 32'(rd),
                                 32'(fn), 32'(imm), 32'(off)));
            if (fmt == 2'd3) m_err = 1'b1;
          end
          if (m_mode == MRun) begin
            if (end_in) m_mode = MDrain;
          end else if (sz == 0) begin
            m_mode = MDone;
          end
        end
        default: m_mode = MIdle;
      endcase
    end
  end

  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_low > 0) begin
        ack_low--;
        ack = 1'b0;
      end else begin
        ack = ($urandom_range(0, 99) < ack_pct);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a);
    start_in   = 1'b1;
    start_addr = a;
    tick();
    start_in   = 1'b0;
  endtask

  task automatic pulse_end();
    end_in = 1'b1;
    tick();
    end_in = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done_timeout", 32'(done), 32'd1);
    tick();
  endtask

  task automatic rand_fields(input bit allow_illegal);
    fmt    = (allow_illegal && $urandom_range(0, 6) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    opcode = 6'($urandom);
    rs1    = 5'($urandom);
    rs2    = 5'($urandom);
    rd     = 5'($urandom);
    fn     = 6'($urandom);
    imm    = 16'($urandom);
    off    = 26'($urandom);
  endtask

  // Called just after a rising edge; holds the record until the DUT takes it.
  task automatic send_cur(input bit with_end);
    bit ok = 1'b0;
    enc_valid = 1'b1;
    for (int w = 0; w < 300 && !ok; w++) begin
      if (ready) begin
        ok     = 1'b1;
        end_in = with_end;
      end
      tick();
    end
    if (!ok) check("send_timeout", 32'(ready), 32'd1);
    enc_valid = 1'b0;
    end_in    = 1'b0;
  endtask

  task automatic log_clear();
    log_addr.delete();
    log_data.delete();
    log8_addr.delete();
  endtask

  initial begin
    int n;
    n_total = 0;
    n_bad   = 0;
    ack_pct = 100;
    ack_low = 0;
    rst_n = 1'b0;
    start_in = 1'b0;
    start_addr = '0;
    end_in = 1'b0;
    enc_valid = 1'b0;
    rand_fields(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    pulse_end();
    tick();
    check("end_in_idle", 32'(busy), 32'd0);

    // Single R-type record
    log_clear();
    do_start(32'h100);
    fmt = 2'd0; opcode = 6'h00; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; fn = 6'h20;
    send_cur(1'b0);
    pulse_end();
    wait_done();
    check("t1_nwr", 32'(log_addr.size()), 32'd1);
    check("t1_addr", log_addr[0], 32'h100);
    check("t1_data", log_data[0], 32'h0022_1820);
    check("t1_count", 32'(count), 32'd1);

    // I then J, end coinciding with the last handshake
    log_clear();
    do_start(32'h2000);
    rand_fields(1'b0);
    fmt = 2'd1; opcode = 6'h08; rs1 = 5'd2; rd = 5'd5; imm = 16'hFFFF;
    send_cur(1'b0);
    rand_fields(1'b0);
    fmt = 2'd2; opcode = 6'h02; off = 26'h100;
    send_cur(1'b1);
    wait_done();
    check("t2_nwr", 32'(log_addr.size()), 32'd2);
    check("t2_data0", log_data[0], 32'h2045_FFFF);
    check("t2_data1", log_data[1], 32'h0800_0100);
    check("t2_addr1", log_addr[1], 32'h2004);

    // Back-pressure: ack withheld until the FIFO fills
    log_clear();
    do_start(32'h40);
    ack_low = 12;
    for (int r = 0; r < 4; r++) begin
      rand_fields(1'b0);
      send_cur(1'b0);
    end
    check("t3_ready_full", 32'(ready), 32'd0);
    check("t3_wr_en_held", 32'(wr_en), 32'd1);
    check("t3_addr_held", addr, 32'h40);
    for (int r = 0; r < 2; r++) begin
      rand_fields(1'b0);
      send_cur(1'b0);
    end
    pulse_end();
    wait_done();
    check("t3_count", 32'(count), 32'd6);
    check("t3_last_addr", log_addr[5], 32'h54);

    // Address wrap on the 8-bit instance
    log_clear();
    do_start(32'hFC);
    for (int r = 0; r < 2; r++) begin
      rand_fields(1'b0);
      send_cur(1'b0);
    end
    pulse_end();
    wait_done();
    check("t4_addr1_32", log_addr[1], 32'h100);
    check("t4_addr0_8", 32'(log8_addr[0]), 32'hFC);
    check("t4_addr1_8", 32'(log8_addr[1]), 32'h00);

    // Illegal format: NOP word and sticky error
    log_clear();
    do_start(32'h500);
    rand_fields(1'b0);
    fmt = 2'd3;
    send_cur(1'b0);
    pulse_end();
    wait_done();
    check("t5_data", log_data[0], 32'h0);
    check("t5_err", 32'(err), 32'd1);
    repeat (3) tick();
    check("t5_err_sticky", 32'(err), 32'd1);
    do_start(32'h600);
    check("t5_err_clear", 32'(err), 32'd0);
    pulse_end();
    wait_done();

    // Reset in the middle of a pending write
    do_start(32'h300);
    ack_low = 30;
    for (int r = 0; r < 3; r++) begin
      rand_fields(1'b0);
      send_cur(1'b0);
    end
    check("t6_wr_pending", 32'(wr_en), 32'd1);
    log_clear();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_wr_en", 32'(wr_en), 32'd0);
    check("t6_addr", addr, 32'd0);
    check("t6_data", data, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_d8_wr_en", 32'(d8_wr_en), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ack_low = 0;
    repeat (10) tick();
    check("t6_no_writes", 32'(log_addr.size()), 32'd0);

    // Random sessions
    for (int s = 0; s < 8; s++) begin
      ack_pct = $urandom_range(20, 100);
      do_start($urandom);
      n = $urandom_range(3, 16);
      for (int r = 0; r < n; r++) begin
        rand_fields(1'b1);
        if ($urandom_range(0, 4) == 0) do_start($urandom);
        repeat ($urandom_range(0, 2)) tick();
        send_cur(r == n - 1 && s[0]);
      end
      if (!s[0]) pulse_end();
      wait_done();
      check("sess_count", 32'(count), 32'(n));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
